// File: rtl/booth_ctrl_unit.sv
// ---------------------------------------------------------------------------
// booth_ctrl_unit
// Control FSM for a radix-2 Booth multiplier. It sequences an external
// datapath holding A, Q, M and the extra bit Q(-1). One multiply is WIDTH
// iterations. Each iteration has a TEST step, an optional ADD or SUB step,
// and an arithmetic right SHIFT.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : begin a multiply (sampled only while idle)
//   q0, q_1    : Q[0] and Q(-1) from the datapath, used to pick the Booth op
//   load_regs  : datapath loads A<=0, Q<=multiplier, M<=multiplicand, Q(-1)<=0
//   add_en     : datapath A <= A + M
//   sub_en     : datapath A <= A - M
//   shift_en   : datapath arithmetic right shift of {A,Q,Q(-1)}
//   busy       : high whenever the FSM is not idle
//   done       : one-cycle pulse, product is valid in the datapath
//   state_dbg  : raw one-hot state {END,SHIFT,SUB,ADD,TEST,LOAD,IDLE}
// ---------------------------------------------------------------------------
module booth_ctrl_unit #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q0,
  input  logic       q_1,
  output logic       load_regs,
  output logic       add_en,
  output logic       sub_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic [6:0] state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_LOAD  = 7'b0000010,
    S_TEST  = 7'b0000100,
    S_ADD   = 7'b0001000,
    S_SUB   = 7'b0010000,
    S_SHIFT = 7'b0100000,
    S_END   = 7'b1000000
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] iter_cnt;
  logic [CW-1:0] iter_cnt_next;

  // State and iteration counter registers. Reset leaves only the IDLE bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_next;
      iter_cnt <= iter_cnt_next;
    end
  end

  // Next-state and counter logic. The counter holds its value unless this is
  // LOAD (clear) or SHIFT (increment). The compare in SHIFT uses the count
  // before the increment. Any state vector that is not one-hot falls into
  // the default arm, which goes back to IDLE and clears the counter.
  always_comb begin
    state_next    = state;
    iter_cnt_next = iter_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        iter_cnt_next = '0;
        state_next    = S_TEST;
      end
      S_TEST: begin
        case ({q0, q_1})
          2'b01:   state_next = S_ADD;
          2'b10:   state_next = S_SUB;
          default: state_next = S_SHIFT;
        endcase
      end
      S_ADD:  state_next = S_SHIFT;
      S_SUB:  state_next = S_SHIFT;
      S_SHIFT: begin
        iter_cnt_next = iter_cnt + 1'b1;
        state_next    = (iter_cnt == LAST_ITER) ? S_END : S_TEST;
      end
      S_END:  state_next = S_IDLE;
      default: begin
        state_next    = S_IDLE;
        iter_cnt_next = '0;
      end
    endcase
  end

  // Moore outputs are taken straight from the state bits. A corrupted
  // vector is therefore decoded as-is for the one cycle it exists.
  assign state_dbg = state;
  assign load_regs = state[1];
  assign add_en    = state[3];
  assign sub_en    = state[4];
  assign shift_en  = state[5];
  assign done      = state[6];
  assign busy      = ~state[0];

endmodule

// File: tb/tb_booth_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_booth_ctrl_unit
// Testbench for booth_ctrl_unit with WIDTH=8. The bench contains a behavioural
// Booth datapath that the DUT controls drive, and that feeds q0/q_1 back.
// Each issued multiply pushes its hand-computed product, latency and ADD/SUB
// visit counts into a queue. A negedge monitor pops one entry on every done
// pulse.
// ---------------------------------------------------------------------------
module tb_booth_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       q0;
  logic       q_1;
  logic       load_regs;
  logic       add_en;
  logic       sub_en;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic [6:0] state_dbg;

  booth_ctrl_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q0        (q0),
    .q_1       (q_1),
    .load_regs (load_regs),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Free-running cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Booth datapath driven by the controller.
  logic [7:0] op_mult  = 8'h00;
  logic [7:0] op_mcand = 8'h00;
  logic [7:0] dp_a     = 8'h00;
  logic [7:0] dp_q     = 8'h00;
  logic [7:0] dp_m     = 8'h00;
  logic       dp_q1    = 1'b0;

  assign q0  = dp_q[0];
  assign q_1 = dp_q1;

  always @(posedge clk) begin
    if (load_regs) begin
      dp_a  <= 8'h00;
      dp_q  <= op_mult;
      dp_m  <= op_mcand;
      dp_q1 <= 1'b0;
    end else if (add_en) begin
      dp_a <= dp_a + dp_m;
    end else if (sub_en) begin
      dp_a <= dp_a - dp_m;
    end else if (shift_en) begin
      {dp_a, dp_q, dp_q1} <= {dp_a[7], dp_a, dp_q};
    end
  end

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          adds;
    int          subs;
  } exp_t;

  exp_t exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Monitor: it tracks when LOAD occurs and counts ADD/SUB visits. On each
  // done pulse it checks the product and the latency against the oldest
  // expected entry.
  int   load_cyc  = 0;
  int   add_cnt   = 0;
  int   sub_cnt   = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (load_regs) begin
        load_cyc = cyc;
        add_cnt  = 0;
        sub_cnt  = 0;
      end
      if (add_en) add_cnt++;
      if (sub_en) sub_cnt++;
      if (done) begin
        checkOutput("done_single_cycle", 32'(prev_done), 32'h0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("product", 32'({dp_a, dp_q}), 32'(e.prod));
          checkOutput("latency", 32'(cyc - load_cyc + 1), 32'(e.lat));
          checkOutput("add_visits", 32'(add_cnt), 32'(e.adds));
          checkOutput("sub_visits", 32'(sub_cnt), 32'(e.subs));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Wait for done within a cycle budget. A timeout counts as a failure.
  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles want done", budget);
    end
  endtask

  // Issue one multiply with a single-cycle start pulse, queue its expected
  // result, and wait for its done pulse.
  task automatic applyStimulus(input logic [7:0] mult, input logic [7:0] mcand,
                               input logic [15:0] prod, input int lat,
                               input int adds, input int subs);
    exp_t e;
    @(negedge clk);
    op_mult  = mult;
    op_mcand = mcand;
    e.prod = prod;
    e.lat  = lat;
    e.adds = adds;
    e.subs = subs;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(60);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_state"}, 32'(state_dbg), 32'h01);
    checkOutput({name, "_ctrl"}, 32'({load_regs, add_en, sub_en, shift_en, done}), 32'h0);
    checkOutput({name, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b1;
    // Reset has priority over start: the DUT must stay idle while reset is low.
    repeat (2) @(negedge clk);
    checkIdle("reset_with_start");
    start = 1'b0;
    #2 reset = 1'b1;

    // With start low, the DUT must remain quiet and idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkIdle("idle_quiet");
    end

    // Multiplier 0: TEST/SHIFT pairs only.
    applyStimulus(8'h00, 8'h05, 16'h0000, 18, 0, 0);
    // 3 * 7: SUB on iteration 0, ADD on iteration 2.
    applyStimulus(8'h03, 8'h07, 16'h0015, 20, 1, 1);
    // -1 * 2: SUB on iteration 0 only.
    applyStimulus(8'hFF, 8'h02, 16'hFFFE, 19, 0, 1);

    // A start pulse in the middle of an operation must be ignored.
    begin
      exp_t e;
      @(negedge clk);
      op_mult  = 8'h00;
      op_mcand = 8'h05;
      e.prod = 16'h0000; e.lat = 18; e.adds = 0; e.subs = 0;
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(60);
      repeat (25) @(negedge clk);
      checkOutput("no_requeue_idle", 32'(busy), 32'h0);
    end

    // Start held high: two back-to-back ops separated by one IDLE cycle.
    begin
      exp_t e;
      @(negedge clk);
      op_mult  = 8'hFF;
      op_mcand = 8'h02;
      e.prod = 16'hFFFE; e.lat = 19; e.adds = 0; e.subs = 1;
      exp_q.push_back(e);
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      waitDone(60);
      @(negedge clk);
      checkOutput("held_gap_idle", 32'(state_dbg), 32'h01);
      @(negedge clk);
      checkOutput("held_reload", 32'(load_regs), 32'h1);
      start = 1'b0;
      @(negedge clk);
      waitDone(60);
    end

    // Reset during the SUB of iteration 3 aborts the op with no done pulse.
    @(negedge clk);
    op_mult  = 8'h08;
    op_mcand = 8'h03;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sub_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_sub", 32'(sub_en), 32'h1);
    #2 reset = 1'b0;
    #1;
    checkIdle("async_abort");
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkIdle("after_abort");
    // 8 * 3 = 24: SUB on iteration 3, ADD on iteration 4.
    applyStimulus(8'h08, 8'h03, 16'h0018, 20, 1, 1);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hang want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/booth_ctrl_unit.md
BOOTH_CTRL_UNIT -- requirements
Module: booth_ctrl_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (number of Booth iterations); legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting low forces reset state immediately, independent of clk.
REQ-004 start  input  1  request to begin one multiply; sampled only in IDLE.
REQ-005 q0  input  1  LSB of multiplier register Q from datapath.
REQ-006 q_1  input  1  Booth extra bit Q(-1) from datapath.
REQ-007 load_regs  output  1  datapath loads A<=0, Q<=multiplier, M<=multiplicand, Q(-1)<=0.
REQ-008 add_en  output  1  datapath A <= A + M.
REQ-009 sub_en  output  1  datapath A <= A - M.
REQ-010 shift_en  output  1  datapath arithmetic right shift of {A,Q,Q(-1)}.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle pulse; product valid in datapath.
REQ-013 state_dbg  output  7  one-hot state vector {END,SHIFT,SUB,ADD,TEST,LOAD,IDLE}, bit 0 = IDLE.

Function
REQ-014 State register one-hot, 7 flops; IDLE flop resets to 1, all others to 0.
REQ-015 Outputs Moore-decoded from state only: load_regs=LOAD, add_en=ADD, sub_en=SUB, shift_en=SHIFT, done=END, busy=~IDLE; at most one of load_regs/add_en/sub_en/shift_en high per cycle.
REQ-016 IDLE: start=1 -> LOAD; else stay IDLE.
REQ-017 LOAD -> TEST unconditionally; iteration counter cleared to 0.
REQ-018 TEST: {q0,q_1}=01 -> ADD; 10 -> SUB; 00 or 11 -> SHIFT.
REQ-019 ADD -> SHIFT; SUB -> SHIFT unconditionally.
REQ-020 SHIFT: counter increments by 1; if counter (pre-increment) == WIDTH-1 -> END, else -> TEST.
REQ-021 Counter width ceil(log2(WIDTH))+1 bits; never wraps during a legal operation; held in all states other than LOAD and SHIFT.
REQ-022 END -> IDLE unconditionally; done high exactly one cycle.
REQ-023 start ignored while busy=1; no queueing of requests.
REQ-024 start held high continuously: END -> IDLE -> LOAD, i.e. back-to-back operations separated by one IDLE cycle.
REQ-025 Latency from start sampled in IDLE to done high: 2 + 2*WIDTH + (number of ADD/SUB visits) cycles; WIDTH=8 range 18..26.
REQ-026 Illegal state vector (zero or more than one bit set): next state IDLE, counter cleared; outputs decode as-is for that one cycle.

Reset
REQ-027 reset low: state_dbg=7'b0000001, counter=0, load_regs=add_en=sub_en=shift_en=done=0, busy=0, asynchronously.
REQ-028 reset low mid-operation aborts it; no done pulse produced; after reset release, first state change occurs only on a clk edge with start=1.
REQ-029 reset has priority over all transitions, including simultaneous start.

Verification
REQ-030 reset low then high, start=0 for 5 cycles -> state_dbg=0000001, all controls 0, busy=0 throughout.
REQ-031 WIDTH=8, bench Booth datapath model, multiplier=0x00, multiplicand=0x05, start pulse -> 8 TEST/SHIFT pairs, no add_en/sub_en, done 18 cycles after start, product 0x0000.
REQ-032 multiplier=0x03 (bits 00000011), multiplicand=0x07 -> SUB on iteration 0, ADD on iteration 2, done at cycle 20, product 0x0015 (21).
REQ-033 multiplier=0xFF (-1), multiplicand=0x02 -> SUB on iteration 0 only, done at cycle 19, product 0xFFFE (-2).
REQ-034 start pulsed again at cycle 5 of an operation -> ignored, single done; start held high across END -> LOAD follows one IDLE cycle after done.
REQ-035 reset asserted low during SUB of iteration 3 -> immediate IDLE, no done pulse; new start -> full correct multiply with exact latency per REQ-025.
